// File: rtl/demux_sched.sv
// demux_sched: single-entry hold register that hands each accepted item to
// one of four output ports, rotating round-robin over the ports enabled in
// en_mask. One item is in flight at a time (IDLE -> HOLD -> IDLE).
// Optional feature: define DEMUX_SCHED_TIMEOUT_EN to add a stall timer that
// redirects a held item to the next enabled port after TIMEOUT cycles.
module demux_sched #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [3:0]       en_mask,
  input  logic [3:0]       y_ready,
  output logic [3:0]       y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic [1:0]       sel,
  output logic [7:0]       count,
  output logic             skip
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       count_q, count_d;

  // First enabled port searching start, start+1, ... (mod 4).
  function automatic logic [1:0] first_enabled(input logic [3:0] mask,
                                               input logic [1:0] start);
    logic [1:0] idx;
    first_enabled = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (mask[idx]) first_enabled = idx;
    end
  endfunction

`ifdef DEMUX_SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              skip_q, skip_d;

  // Next enabled port strictly after cur; stays on cur if it is the only one.
  function automatic logic [1:0] next_enabled(input logic [3:0] mask,
                                              input logic [1:0] cur);
    logic [1:0] idx;
    next_enabled = cur;
    for (int i = 3; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (mask[idx]) next_enabled = idx;
    end
  endfunction
`endif

  // Accept only from IDLE and only when some port can take the item.
  assign in_ready = (state_q == IDLE) && (en_mask != 4'b0000);

  // Next-state logic for the FSM, pointer, hold register and counters.
  always_comb begin
    // NOTE: every _d gets a default of its _q first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    count_d = count_q;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    wait_d  = wait_q;
    skip_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = HOLD;
          data_d  = in_data;
          sel_d   = first_enabled(en_mask, ptr_q);
`ifdef DEMUX_SCHED_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      HOLD: begin
        // Only the latched target's ready matters; en_mask is not consulted.
        if (y_ready[sel_q]) begin
          state_d = IDLE;
          count_d = count_q + 8'd1;
          ptr_d   = sel_q + 2'd1;
        end
`ifdef DEMUX_SCHED_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          sel_d  = next_enabled(en_mask, sel_q);
          wait_d = '0;
          skip_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset empties the block and drops any held item.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      // NOTE: the hold register is reset too so y_data reads 0 out of reset
      // rather than stale contents of a discarded item.
      data_q  <= '0;
      count_q <= 8'd0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      wait_q  <= '0;
      skip_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      count_q <= count_d;
`ifdef DEMUX_SCHED_TIMEOUT_EN
      wait_q  <= wait_d;
      skip_q  <= skip_d;
`endif
    end
  end

  assign y_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
  assign y_data  = data_q;
  assign sel     = sel_q;
  assign count   = count_q;
`ifdef DEMUX_SCHED_TIMEOUT_EN
  assign skip    = skip_q;
`else
  assign skip    = 1'b0;
`endif

endmodule

// File: doc/demux_sched.md
DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, cycles to wait on a stalled port (used only when DEMUX_SCHED_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream item valid.
REQ-006 SHALL have port in_data, input, WIDTH, upstream item.
REQ-007 SHALL have port in_ready, output, 1, block can accept an item.
REQ-008 SHALL have port en_mask, input, 4, bit i = 1 enables output port i for rotation.
REQ-009 SHALL have port y_ready, input, 4, per-port downstream ready.
REQ-010 SHALL have port y_valid, output, 4, per-port valid; at most one bit set.
REQ-011 SHALL have port y_data, output, WIDTH, held item, shared by all ports; qualified by y_valid.
REQ-012 SHALL have port sel, output, 2, index of the current target port (demux select).
REQ-013 SHALL have port count, output, 8, total items delivered, wraps 255->0.
REQ-014 SHALL have port skip, output, 1, one-cycle pulse on a timeout redirect.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (empty) and HOLD (item registered, awaiting delivery).
REQ-016 In IDLE, in_ready SHALL be 1 iff en_mask != 0; in HOLD, in_ready SHALL be 0.
REQ-017 IDLE->HOLD SHALL occur when in_valid && in_ready: in_data captured into the hold register; sel latched to the first enabled port found searching ptr, ptr+1, ... (mod 4).
REQ-018 In HOLD, y_valid[sel] SHALL be 1 and all other y_valid bits 0; y_valid SHALL be 0 in IDLE.
REQ-019 HOLD->IDLE SHALL occur when y_ready[sel] = 1: count increments by 1 (mod 256), ptr <= sel+1 (mod 4).
REQ-020 Throughput SHALL be one item per two cycles at best; latency from accept to y_valid SHALL be exactly 1 cycle.
REQ-021 en_mask changes during HOLD SHALL NOT alter sel; the held item is delivered to the latched port.
REQ-022 en_mask = 0 in IDLE SHALL hold in_ready at 0; ptr unchanged.
REQ-023 y_data and sel SHALL stay stable throughout HOLD until delivery.
REQ-024 y_ready on non-selected ports SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, ptr 0, sel 0, y_valid 0, y_data 0, count 0, skip 0; in_ready then follows REQ-016.
REQ-026 Reset asserted in HOLD SHALL discard the held item with no delivery and no count increment.

Configuration
REQ-027 Macro DEMUX_SCHED_TIMEOUT_EN defined: a wait counter SHALL clear on HOLD entry and increment each HOLD cycle with y_ready[sel] = 0; on reaching TIMEOUT, sel SHALL move to the next enabled port after sel (or stay if no other port is enabled), the counter SHALL clear, and skip SHALL pulse for one cycle.
REQ-028 Macro not defined: no wait counter; HOLD waits indefinitely; skip SHALL be tied 0.

Verification
REQ-029 en_mask=1111, all y_ready=1, four items 0x11,0x22,0x33,0x44 -> delivered on ports 0,1,2,3 in order; count=4.
REQ-030 en_mask=1010, y_ready=1111, three items -> ports 1,3,1; y_valid[0] and y_valid[2] never set.
REQ-031 Item held on port 2 with y_ready[2]=0 for 5 cycles, then 1 -> y_valid=0100 and y_data stable for 6 cycles; delivery on the 6th; in_ready=0 throughout.
REQ-032 en_mask=0000, in_valid=1 -> in_ready=0, y_valid=0000; then en_mask=0100 -> next accept targets port 2.
REQ-033 rst_n pulsed low mid-HOLD, count=7 -> y_valid=0000, count=0, sel=0 immediately; next item goes to port 0.
REQ-034 With DEMUX_SCHED_TIMEOUT_EN, TIMEOUT=15, en_mask=0011, y_ready=0010, item targeted at port 0 -> after 15 stall cycles skip pulses, sel=1, delivered on port 1.
